// File: rtl/lif_spike_monitor.sv
// Windowed spike-rate monitor for the LIF network spike bus: per-window rate, active-channel mask
// and saturation flag. Define LIF_SPIKE_MON_ISI_EN to add channel-0 inter-spike-interval timing.
module lif_spike_monitor #(
    parameter int unsigned N_CH     = 8,
    parameter int unsigned WIN_LOG2 = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic [N_CH-1:0]  spike_in,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    output logic [N_CH-1:0]  active_ch,
    output logic             sat_flag,
    output logic [15:0]      isi_out,
    output logic             isi_valid
);

    localparam int unsigned PopW = $clog2(N_CH + 1);
    localparam int unsigned SumW = CNT_W + PopW;
    localparam logic [CNT_W-1:0] AccMax = '1;

    function automatic logic [PopW-1:0] popcount(input logic [N_CH-1:0] v);
        logic [PopW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            n = n + PopW'(v[i]);
        end
        return n;
    endfunction

    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]    acc_q, acc_d;
    logic [N_CH-1:0]     seen_q, seen_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    rate_q, rate_d;
    logic [N_CH-1:0]     active_q, active_d;
    logic                sat_flag_q, sat_flag_d;
    logic                rate_valid_q, rate_valid_d;

    logic [SumW-1:0]  sum;
    logic             ovf;
    logic [CNT_W-1:0] acc_sat;
    logic             win_end;

    always_comb begin
        sum     = SumW'(acc_q) + SumW'(popcount(spike_in));
        ovf     = sum > SumW'(AccMax);
        acc_sat = ovf ? AccMax : sum[CNT_W-1:0];
        win_end = (win_cnt_q == '1);

        win_cnt_d    = win_cnt_q;
        acc_d        = acc_q;
        seen_d       = seen_q;
        sat_d        = sat_q;
        rate_d       = rate_q;
        active_d     = active_q;
        sat_flag_d   = sat_flag_q;
        rate_valid_d = 1'b0;

        // clr restarts the window but keeps the last published results
        if (clr) begin
            win_cnt_d = '0;
            acc_d     = '0;
            seen_d    = '0;
            sat_d     = 1'b0;
        end else if (ena) begin
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
            if (win_end) begin
                rate_d       = acc_sat;
                active_d     = seen_q | spike_in;
                sat_flag_d   = sat_q | ovf;
                rate_valid_d = 1'b1;
                acc_d        = '0;
                seen_d       = '0;
                sat_d        = 1'b0;
            end else begin
                acc_d  = acc_sat;
                seen_d = seen_q | spike_in;
                sat_d  = sat_q | ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q    <= '0;
            acc_q        <= '0;
            seen_q       <= '0;
            sat_q        <= 1'b0;
            rate_q       <= '0;
            active_q     <= '0;
            sat_flag_q   <= 1'b0;
            rate_valid_q <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            acc_q        <= acc_d;
            seen_q       <= seen_d;
            sat_q        <= sat_d;
            rate_q       <= rate_d;
            active_q     <= active_d;
            sat_flag_q   <= sat_flag_d;
            rate_valid_q <= rate_valid_d;
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = rate_valid_q;
    assign active_ch  = active_q;
    assign sat_flag   = sat_flag_q;

`ifdef LIF_SPIKE_MON_ISI_EN
    typedef enum logic [0:0] {StNoRef, StTiming} isi_state_e;

    isi_state_e  state_q, state_d;
    logic [15:0] isi_cnt_q, isi_cnt_d;
    logic [15:0] isi_out_q, isi_out_d;
    logic        isi_valid_q, isi_valid_d;

    always_comb begin
        state_d     = state_q;
        isi_cnt_d   = isi_cnt_q;
        isi_out_d   = isi_out_q;
        isi_valid_d = 1'b0;
        if (clr) begin
            state_d = StNoRef;
        end else if (ena) begin
            unique case (state_q)
                StNoRef: begin
                    if (spike_in[0]) begin
                        state_d   = StTiming;
                        isi_cnt_d = 16'd1;
                    end
                end
                StTiming: begin
                    if (spike_in[0]) begin
                        isi_out_d   = isi_cnt_q;
                        isi_valid_d = 1'b1;
                        isi_cnt_d   = 16'd1;
                    end else if (isi_cnt_q != 16'hFFFF) begin
                        // sticks at all-ones so an overlong interval reports 16'hFFFF
                        isi_cnt_d = isi_cnt_q + 16'd1;
                    end
                end
                default: state_d = StNoRef;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StNoRef;
            isi_cnt_q   <= '0;
            isi_out_q   <= '0;
            isi_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            isi_cnt_q   <= isi_cnt_d;
            isi_out_q   <= isi_out_d;
            isi_valid_q <= isi_valid_d;
        end
    end

    assign isi_out   = isi_out_q;
    assign isi_valid = isi_valid_q;
`else
    assign isi_out   = 16'h0;
    assign isi_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Scoreboard bench for lif_spike_monitor: directed stimulus pushes expected pulses (with their
// cycle stamps) into queues; negedge monitors pop and compare whenever a valid pulse appears.
module tb_lif_spike_monitor;

    logic        clk = 1'b0;
    logic        rst, ena, clr;
    logic [7:0]  spike_in;
    logic [7:0]  rate_out, active_ch;
    logic        rate_valid, sat_flag, isi_valid;
    logic [15:0] isi_out;

    logic        ena6;
    logic [7:0]  spike6;
    logic [7:0]  rate_out6, active_ch6;
    logic        rate_valid6, sat_flag6, isi_valid6;
    logic [15:0] isi_out6;

    always #5 clk = ~clk;

    lif_spike_monitor #(.N_CH(8), .WIN_LOG2(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .clr(clr), .spike_in(spike_in),
        .rate_out(rate_out), .rate_valid(rate_valid), .active_ch(active_ch),
        .sat_flag(sat_flag), .isi_out(isi_out), .isi_valid(isi_valid)
    );

    lif_spike_monitor #(.N_CH(8), .WIN_LOG2(6), .CNT_W(8)) dut6 (
        .clk(clk), .rst(rst), .ena(ena6), .clr(1'b0), .spike_in(spike6),
        .rate_out(rate_out6), .rate_valid(rate_valid6), .active_ch(active_ch6),
        .sat_flag(sat_flag6), .isi_out(isi_out6), .isi_valid(isi_valid6)
    );

    typedef struct {
        int         cyc;
        logic [7:0] rate;
        logic [7:0] act;
        logic       sat;
    } rate_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] val;
    } isi_exp_t;

    rate_exp_t q_rate[$];
    rate_exp_t q_rate6[$];
    isi_exp_t  q_isi[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    bit rate_chk = 1'b1;
    bit isi_chk = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_rate(input bit big, input int c, input logic [7:0] r,
                             input logic [7:0] a, input logic s);
        rate_exp_t e;
        e.cyc = c; e.rate = r; e.act = a; e.sat = s;
        if (big) q_rate6.push_back(e);
        else     q_rate.push_back(e);
    endtask

    task automatic push_isi(input int c, input logic [15:0] v);
        isi_exp_t e;
        e.cyc = c; e.val = v;
        q_isi.push_back(e);
    endtask

    task automatic step(input logic e, input logic c, input logic [7:0] s);
        ena = e; clr = c; spike_in = s;
        @(posedge clk);
        #1;
    endtask

    // Monitors: sample half a cycle away from the active edge
    always @(negedge clk) begin
        rate_exp_t e;
        isi_exp_t  ie;
        if (rate_chk && rate_valid === 1'b1) begin
            if (q_rate.size() == 0) begin
                check("rate_pulse_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = q_rate.pop_front();
                check("rate_cycle", 32'(cyc), 32'(e.cyc));
                check("rate_out", 32'(rate_out), 32'(e.rate));
                check("active_ch", 32'(active_ch), 32'(e.act));
                check("sat_flag", 32'(sat_flag), 32'(e.sat));
            end
        end
        if (rate_valid6 === 1'b1) begin
            if (q_rate6.size() == 0) begin
                check("rate6_pulse_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                e = q_rate6.pop_front();
                check("rate6_cycle", 32'(cyc), 32'(e.cyc));
                check("rate6_out", 32'(rate_out6), 32'(e.rate));
                check("active6_ch", 32'(active_ch6), 32'(e.act));
                check("sat6_flag", 32'(sat_flag6), 32'(e.sat));
            end
        end
        if (isi_chk && isi_valid === 1'b1) begin
            if (q_isi.size() == 0) begin
                check("isi_pulse_unexpected", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                ie = q_isi.pop_front();
                check("isi_cycle", 32'(cyc), 32'(ie.cyc));
                check("isi_out", 32'(isi_out), 32'(ie.val));
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1; ena = 1'b0; clr = 1'b0; spike_in = '0;
        ena6 = 1'b0; spike6 = '0;

        // 1: reset with random spikes
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            check("rst_rate_out", 32'(rate_out), 32'h0);
            check("rst_active_ch", 32'(active_ch), 32'h0);
            check("rst_sat_flag", 32'(sat_flag), 32'h0);
            check("rst_rate_valid", 32'(rate_valid), 32'h0);
            check("rst_isi_out", 32'(isi_out), 32'h0);
            check("rst_isi_valid", 32'(isi_valid), 32'h0);
            check("rst_rate6_out", 32'(rate_out6), 32'h0);
        end
        rst = 1'b0;

        // 2: ch0 every cycle, three windows
        c = cyc;
        push_rate(0, c + 16, 8'd16, 8'h01, 1'b0);
        push_rate(0, c + 32, 8'd16, 8'h01, 1'b0);
        push_rate(0, c + 48, 8'd16, 8'h01, 1'b0);
        for (int i = 0; i < 48; i++) step(1'b1, 1'b0, 8'h01);

        // 3: 64-cycle window, all channels, accumulator saturates
        c = cyc;
        push_rate(1, c + 64, 8'd255, 8'hFF, 1'b1);
        ena6 = 1'b1; spike6 = 8'hFF;
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 8'h00);
        ena6 = 1'b0; spike6 = 8'h00;

        // 4: clr at window cycle 7 restarts the window; published outputs hold
        c = cyc;
        push_rate(0, c + 24, 8'd32, 8'h03, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b1, 8'h03);
        check("clr_hold_rate_out", 32'(rate_out), 32'd16);
        check("clr_hold_active_ch", 32'(active_ch), 32'h01);
        check("clr_rate_valid", 32'(rate_valid), 32'h0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h03);

        // 5: ena low for 5 cycles mid-window stretches the window
        c = cyc;
        push_rate(0, c + 21, 8'd16, 8'h01, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h01);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h01);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h01);

        // Mixed pattern; the last cycle's spike belongs to the closing window
        begin
            logic [7:0] pat [16];
            pat = '{8'h80, 8'h24, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
            c = cyc;
            push_rate(0, c + 16, 8'd5, 8'hB5, 1'b0);
            for (int i = 0; i < 16; i++) step(1'b1, 1'b0, pat[i]);
        end

        // 6: ch0 spikes at enabled cycles 10, 17, 30 after a clr
        step(1'b1, 1'b1, 8'h00);
        c = cyc;
        push_rate(0, c + 16, 8'd1, 8'h01, 1'b0);
`ifdef LIF_SPIKE_MON_ISI_EN
        isi_chk = 1'b1;
        push_isi(c + 18, 16'd7);
        push_isi(c + 31, 16'd13);
`endif
        for (int k = 0; k < 31; k++) begin
            step(1'b1, 1'b0, (k == 10 || k == 17 || k == 30) ? 8'h01 : 8'h00);
`ifndef LIF_SPIKE_MON_ISI_EN
            check("noisi_valid", 32'(isi_valid), 32'h0);
            check("noisi_out", 32'(isi_out), 32'h0);
`endif
        end
`ifdef LIF_SPIKE_MON_ISI_EN
        // Interval beyond 16 bits reports all-ones
        step(1'b1, 1'b0, 8'h00);
        rate_chk = 1'b0;
        for (int i = 0; i < 65598; i++) step(1'b1, 1'b0, 8'h00);
        c = cyc;
        push_isi(c + 1, 16'hFFFF);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h00);
`endif
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        check("rate_queue_drained", 32'(q_rate.size()), 32'd0);
        check("rate6_queue_drained", 32'(q_rate6.size()), 32'd0);
        check("isi_queue_drained", 32'(q_isi.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
